// File: rtl/wshbn_bus_arbiter.sv
// Two-master Wishbone arbiter: M0 (I/O) and M1 (cache) share four slaves
// (PIO, timer, UART, SPI). The grant is registered and round-robin, and it
// is held for the whole CYC. A watchdog forces an error on a missing ACK,
// and a strobe to an unmapped address also produces an error.
module wshbn_bus_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int DW      = 32
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic          M0_CYC_I,
  input  logic          M0_STB_I,
  input  logic          M0_WE_I,
  input  logic [7:0]    M0_ADR_I,
  input  logic [DW-1:0] M0_DAT_I,
  output logic [DW-1:0] M0_DAT_O,
  output logic          M0_ACK_O,
  output logic          M0_ERR_O,
  input  logic          M1_CYC_I,
  input  logic          M1_STB_I,
  input  logic          M1_WE_I,
  input  logic [7:0]    M1_ADR_I,
  input  logic [DW-1:0] M1_DAT_I,
  output logic [DW-1:0] M1_DAT_O,
  output logic          M1_ACK_O,
  output logic          M1_ERR_O,
  output logic          S_CYC_O,
  output logic          S_WE_O,
  output logic [7:0]    S_ADR_O,
  output logic [DW-1:0] S_DAT_O,
  output logic [3:0]    S_STB_O,
  input  logic [DW-1:0] S0_DAT_I,
  input  logic [DW-1:0] S1_DAT_I,
  input  logic [DW-1:0] S2_DAT_I,
  input  logic [DW-1:0] S3_DAT_I,
  input  logic [3:0]    S_ACK_I,
  output logic [1:0]    GNT_O,
  output logic          BUSY_O
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN = 2'd1, ERR = 2'd2} state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [1:0]    gnt, gnt_nxt;
  logic          last_gnt, last_gnt_nxt;   // 1 = M1 was the last owner
  logic [7:0]    wait_cnt, wait_cnt_nxt;

  logic          req0, req1;
  logic          g_cyc, g_stb, g_we;
  logic [7:0]    g_adr;
  logic [DW-1:0] g_dat;
  logic          mapped;
  logic [1:0]    slv;
  logic          sel_ack;
  logic [DW-1:0] sel_dat;
  logic          ack, err;
  logic [DW-1:0] rd_dat;

  assign req0   = M0_CYC_I & M0_STB_I;
  assign req1   = M1_CYC_I & M1_STB_I;
  assign mapped = (g_adr[7:6] == 2'b00);
  assign slv    = g_adr[5:4];

  // Select the signals of whichever master currently holds the grant
  always_comb begin
    g_cyc = 1'b0;
    g_stb = 1'b0;
    g_we  = 1'b0;
    g_adr = '0;
    g_dat = '0;
    if (gnt[0]) begin
      g_cyc = M0_CYC_I;
      g_stb = M0_STB_I;
      g_we  = M0_WE_I;
      g_adr = M0_ADR_I;
      g_dat = M0_DAT_I;
    end else if (gnt[1]) begin
      g_cyc = M1_CYC_I;
      g_stb = M1_STB_I;
      g_we  = M1_WE_I;
      g_adr = M1_ADR_I;
      g_dat = M1_DAT_I;
    end
  end

  // Pick the addressed slave's acknowledge and read data
  always_comb begin
    sel_ack = mapped & S_ACK_I[slv];
    case (slv)
      2'd0:    sel_dat = S0_DAT_I;
      2'd1:    sel_dat = S1_DAT_I;
      2'd2:    sel_dat = S2_DAT_I;
      default: sel_dat = S3_DAT_I;
    endcase
  end

  // State, grant, round-robin history and wait counter registers
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state    <= IDLE;
      gnt      <= 2'b00;
      last_gnt <= 1'b1;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      last_gnt <= last_gnt_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Arbitration, ownership release and timeout/unmapped error decisions
  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    last_gnt_nxt = last_gnt;
    wait_cnt_nxt = '0;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          gnt_nxt   = last_gnt ? 2'b01 : 2'b10;
          state_nxt = OWN;
        end else if (req0) begin
          gnt_nxt   = 2'b01;
          state_nxt = OWN;
        end else if (req1) begin
          gnt_nxt   = 2'b10;
          state_nxt = OWN;
        end
      end
      OWN: begin
        if (!g_cyc) begin
          state_nxt    = IDLE;
          last_gnt_nxt = gnt[1];
          gnt_nxt      = 2'b00;
        end else if (g_stb && !mapped) begin
          state_nxt = ERR;
        end else if (g_stb && !sel_ack) begin
          // An ACK on the limit cycle wins because this branch is not taken
          if (wait_cnt == WAIT_LIMIT) state_nxt = ERR;
          else                        wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      ERR: begin
        if (g_cyc) begin
          state_nxt = OWN;
        end else begin
          state_nxt    = IDLE;
          last_gnt_nxt = gnt[1];
          gnt_nxt      = 2'b00;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 2'b00;
      end
    endcase
  end

  // Slave-side routing and master-side ACK/ERR/read-data return
  always_comb begin
    S_CYC_O  = (state != IDLE);
    S_WE_O   = (state != IDLE) ? g_we  : 1'b0;
    S_ADR_O  = (state != IDLE) ? g_adr : 8'h00;
    S_DAT_O  = (state != IDLE) ? g_dat : '0;
    S_STB_O  = (state == OWN && g_stb && mapped) ? (4'b0001 << slv) : 4'b0000;
    ack      = (state == OWN) & g_stb & sel_ack;
    err      = (state == ERR);
    rd_dat   = (state == OWN && g_stb && mapped) ? sel_dat : '0;
    M0_ACK_O = gnt[0] & ack;
    M0_ERR_O = gnt[0] & err;
    M0_DAT_O = gnt[0] ? rd_dat : '0;
    M1_ACK_O = gnt[1] & ack;
    M1_ERR_O = gnt[1] & err;
    M1_DAT_O = gnt[1] ? rd_dat : '0;
    GNT_O    = gnt;
    BUSY_O   = (state != IDLE);
  end

endmodule

// File: tb/tb_wshbn_bus_arbiter.sv
// Directed bench for wshbn_bus_arbiter: single read, round-robin,
// block-transfer hold, unmapped error, timeout, ACK-on-limit, mid-transfer reset.
module tb_wshbn_bus_arbiter;

  localparam int DW = 32;

  logic          CLK_I = 1'b0;
  logic          RST_I;
  logic          M0_CYC_I, M0_STB_I, M0_WE_I;
  logic [7:0]    M0_ADR_I;
  logic [DW-1:0] M0_DAT_I, M0_DAT_O;
  logic          M0_ACK_O, M0_ERR_O;
  logic          M1_CYC_I, M1_STB_I, M1_WE_I;
  logic [7:0]    M1_ADR_I;
  logic [DW-1:0] M1_DAT_I, M1_DAT_O;
  logic          M1_ACK_O, M1_ERR_O;
  logic          S_CYC_O, S_WE_O;
  logic [7:0]    S_ADR_O;
  logic [DW-1:0] S_DAT_O;
  logic [3:0]    S_STB_O;
  logic [DW-1:0] S0_DAT_I, S1_DAT_I, S2_DAT_I, S3_DAT_I;
  logic [3:0]    S_ACK_I;
  logic [1:0]    GNT_O;
  logic          BUSY_O;

  int n_vec = 0;
  int n_err = 0;

  wshbn_bus_arbiter #(.TIMEOUT(16), .DW(DW)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .M0_CYC_I(M0_CYC_I), .M0_STB_I(M0_STB_I), .M0_WE_I(M0_WE_I),
    .M0_ADR_I(M0_ADR_I), .M0_DAT_I(M0_DAT_I), .M0_DAT_O(M0_DAT_O),
    .M0_ACK_O(M0_ACK_O), .M0_ERR_O(M0_ERR_O),
    .M1_CYC_I(M1_CYC_I), .M1_STB_I(M1_STB_I), .M1_WE_I(M1_WE_I),
    .M1_ADR_I(M1_ADR_I), .M1_DAT_I(M1_DAT_I), .M1_DAT_O(M1_DAT_O),
    .M1_ACK_O(M1_ACK_O), .M1_ERR_O(M1_ERR_O),
    .S_CYC_O(S_CYC_O), .S_WE_O(S_WE_O), .S_ADR_O(S_ADR_O), .S_DAT_O(S_DAT_O),
    .S_STB_O(S_STB_O),
    .S0_DAT_I(S0_DAT_I), .S1_DAT_I(S1_DAT_I), .S2_DAT_I(S2_DAT_I), .S3_DAT_I(S3_DAT_I),
    .S_ACK_I(S_ACK_I), .GNT_O(GNT_O), .BUSY_O(BUSY_O)
  );

  always #5 CLK_I = ~CLK_I;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic drive_m0(input logic cyc, input logic stb, input logic we, input logic [7:0] adr);
    M0_CYC_I = cyc; M0_STB_I = stb; M0_WE_I = we; M0_ADR_I = adr;
  endtask

  task automatic drive_m1(input logic cyc, input logic stb, input logic we, input logic [7:0] adr);
    M1_CYC_I = cyc; M1_STB_I = stb; M1_WE_I = we; M1_ADR_I = adr;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_gnt"},  GNT_O, 2'b00);
    check_val({tag, "_busy"}, BUSY_O, 1'b0);
    check_val({tag, "_scyc"}, S_CYC_O, 1'b0);
    check_val({tag, "_sstb"}, S_STB_O, 4'b0000);
    check_val({tag, "_sadr"}, S_ADR_O, 8'h00);
    check_val({tag, "_acks"}, {M0_ACK_O, M0_ERR_O, M1_ACK_O, M1_ERR_O}, 4'b0000);
    check_val({tag, "_dat"},  {M0_DAT_O, M1_DAT_O}, 64'h0);
  endtask

  task automatic do_reset();
    tick();
    RST_I = 1'b0;
    #1;
    check_all_zero("rst");
    RST_I = 1'b1;
  endtask

  initial begin
    RST_I = 1'b0;
    drive_m0(0, 0, 0, 8'h00); M0_DAT_I = '0;
    drive_m1(0, 0, 0, 8'h00); M1_DAT_I = '0;
    S0_DAT_I = 32'hA5A5A5A5; S1_DAT_I = 32'h11111111;
    S2_DAT_I = 32'h22222222; S3_DAT_I = 32'h33333333;
    S_ACK_I = 4'b0000;
    #3;
    check_all_zero("por");
    RST_I = 1'b1;

    // Single read by M0 from PIO, ACK on the third strobed cycle
    tick();
    drive_m0(1, 1, 0, 8'h04);
    #1;
    check_val("rd_req_gnt", GNT_O, 2'b00);
    check_val("rd_req_stb", S_STB_O, 4'b0000);
    tick();
    check_val("rd_own_gnt", GNT_O, 2'b01);
    check_val("rd_own_stb", S_STB_O, 4'b0001);
    check_val("rd_own_ack", M0_ACK_O, 1'b0);
    check_val("rd_own_adr", S_ADR_O, 8'h04);
    tick();
    check_val("rd_wait_ack", M0_ACK_O, 1'b0);
    tick();
    S_ACK_I = 4'b0001;
    #1;
    check_val("rd_ack", M0_ACK_O, 1'b1);
    check_val("rd_dat", M0_DAT_O, 32'hA5A5A5A5);
    check_val("rd_m1_quiet", {M1_ACK_O, M1_ERR_O, M1_DAT_O}, 34'h0);
    check_val("rd_err", M0_ERR_O, 1'b0);
    tick();
    S_ACK_I = 4'b0000; M0_STB_I = 1'b0;
    #1;
    check_val("rd_hold_gnt", GNT_O, 2'b01);
    check_val("rd_nostb", S_STB_O, 4'b0000);
    tick();
    M0_CYC_I = 1'b0;
    #1;
    check_val("rd_drop_gnt", GNT_O, 2'b01);
    tick();
    check_val("rd_idle_gnt", GNT_O, 2'b00);
    check_val("rd_idle_busy", BUSY_O, 1'b0);

    // Round-robin after reset: M0 first, then M1, then M0
    do_reset();
    tick();
    drive_m0(1, 1, 0, 8'h10);
    drive_m1(1, 1, 0, 8'h20);
    tick();
    check_val("rr1_gnt", GNT_O, 2'b01);
    check_val("rr1_stb", S_STB_O, 4'b0010);
    S_ACK_I = 4'b0010;
    #1;
    check_val("rr1_ack", {M0_ACK_O, M1_ACK_O}, 2'b10);
    check_val("rr1_dat", M0_DAT_O, 32'h11111111);
    tick();
    S_ACK_I = 4'b0000;
    drive_m0(0, 0, 0, 8'h10);
    #1;
    check_val("rr1_drop_gnt", GNT_O, 2'b01);
    tick();
    drive_m0(1, 1, 0, 8'h10);
    #1;
    check_val("rr_idle_gnt", GNT_O, 2'b00);
    check_val("rr_idle_busy", BUSY_O, 1'b0);
    tick();
    check_val("rr2_gnt", GNT_O, 2'b10);
    check_val("rr2_stb", S_STB_O, 4'b0100);
    S_ACK_I = 4'b0100;
    #1;
    check_val("rr2_ack", {M0_ACK_O, M1_ACK_O}, 2'b01);
    check_val("rr2_m0dat", M0_DAT_O, 32'h0);
    tick();
    S_ACK_I = 4'b0000;
    drive_m1(0, 0, 0, 8'h00);
    tick();
    check_val("rr3_idle", GNT_O, 2'b00);
    tick();
    check_val("rr3_gnt", GNT_O, 2'b01);
    drive_m0(0, 0, 0, 8'h00);
    tick();
    tick();

    // M1 block of four writes to UART while M0 waits
    drive_m1(1, 1, 1, 8'h20);
    M1_DAT_I = 32'h11110000;
    tick();
    drive_m0(1, 1, 0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      M1_DAT_I = 32'h11110000 + 32'(i);
      S_ACK_I = 4'b0100;
      #1;
      check_val("blk_gnt", GNT_O, 2'b10);
      check_val("blk_stb", S_STB_O, 4'b0100);
      check_val("blk_we",  S_WE_O, 1'b1);
      check_val("blk_dat", S_DAT_O, 32'h11110000 + 32'(i));
      check_val("blk_ack", {M0_ACK_O, M1_ACK_O}, 2'b01);
      tick();
    end
    drive_m1(0, 0, 0, 8'h00);
    S_ACK_I = 4'b0000;
    #1;
    check_val("blk_end_gnt", GNT_O, 2'b10);
    check_val("blk_end_stb", S_STB_O, 4'b0000);
    tick();
    check_val("blk_idle_gnt", GNT_O, 2'b00);
    tick();
    check_val("blk_m0_gnt", GNT_O, 2'b01);
    check_val("blk_m0_stb", S_STB_O, 4'b0001);
    drive_m0(0, 0, 0, 8'h00);
    tick();
    tick();

    // Unmapped address: one-cycle error, then OWN while CYC stays high
    drive_m0(1, 1, 0, 8'h50);
    tick();
    check_val("um_gnt", GNT_O, 2'b01);
    check_val("um_stb", S_STB_O, 4'b0000);
    check_val("um_noerr", M0_ERR_O, 1'b0);
    tick();
    check_val("um_err", M0_ERR_O, 1'b1);
    check_val("um_err_ack", M0_ACK_O, 1'b0);
    check_val("um_err_stb", S_STB_O, 4'b0000);
    check_val("um_err_cyc", S_CYC_O, 1'b1);
    M0_STB_I = 1'b0;
    tick();
    check_val("um_own_err", M0_ERR_O, 1'b0);
    check_val("um_own_busy", {BUSY_O, GNT_O}, 3'b101);
    M0_CYC_I = 1'b0;
    tick();
    check_val("um_idle", BUSY_O, 1'b0);

    // Timer never ACKs: error after exactly 16 strobed cycles
    drive_m0(1, 1, 0, 8'h10);
    tick();
    for (int i = 0; i < 16; i++) begin
      check_val("to_wait_err", M0_ERR_O, 1'b0);
      check_val("to_wait_stb", S_STB_O, 4'b0010);
      tick();
    end
    check_val("to_err", M0_ERR_O, 1'b1);
    check_val("to_err_stb", S_STB_O, 4'b0000);
    tick();
    // Counter restarted: an ACK on the 16th strobed cycle wins over the limit
    for (int i = 0; i < 15; i++) begin
      check_val("lim_wait_err", M0_ERR_O, 1'b0);
      tick();
    end
    S_ACK_I = 4'b0010;
    #1;
    check_val("lim_ack", {M0_ACK_O, M0_ERR_O}, 2'b10);
    tick();
    S_ACK_I = 4'b0000;
    M0_STB_I = 1'b0;
    #1;
    check_val("lim_no_err", M0_ERR_O, 1'b0);
    check_val("lim_own", GNT_O, 2'b01);
    M0_CYC_I = 1'b0;
    tick();
    check_val("lim_idle", BUSY_O, 1'b0);

    // Reset in the middle of an M1 SPI transfer
    drive_m1(1, 1, 0, 8'h30);
    tick();
    check_val("mr_gnt", GNT_O, 2'b10);
    check_val("mr_stb", S_STB_O, 4'b1000);
    #2;
    RST_I = 1'b0;
    S_ACK_I = 4'b1000;
    #1;
    check_all_zero("mr_rst");
    #1;
    RST_I = 1'b1;
    S_ACK_I = 4'b0000;
    #1;
    check_val("mr_rel_gnt", GNT_O, 2'b00);
    tick();
    check_val("mr_regnt", GNT_O, 2'b10);
    check_val("mr_restb", S_STB_O, 4'b1000);
    drive_m1(0, 0, 0, 8'h00);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
